conv2_aer_fetch: RTL and testbench



---
 rtl/conv2_aer_fetch.sv | 130 +++++++++++++
 tb/tb_conv2_aer_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_aer_fetch.sv
// conv2_aer_fetch: pulls AER words from the Pool->Conv2 FIFO, decodes them and hands events to Conv2
// Ports:
//   work_clk, rst_n              clock, synchronous active-low reset
//   enable                       permits starting new FIFO reads
//   FIFO_Pool_Conv2_empty        FIFO empty status
//   Pool_AER_data_FIFO_o(_flag)  FIFO read data and its data-valid level
//   Pool_layer_done              pool layer finished the current timestep (pulse)
//   Read_req                     read request to the FIFO, held until the flag is seen
//   evt_valid/evt_ready          decoded event handshake towards the Conv2 engine
//   evt_ch/evt_row/evt_col       decoded event fields, stable while valid and not ready
//   Conv2_step_done              one-cycle pulse once the timestep is fully drained
//   evt_cnt                      events delivered this timestep (saturating)
//   drop_cnt                     out-of-range words dropped, cumulative (saturating)
module conv2_aer_fetch #(
    parameter int AER_W       = 12,
    parameter int CH_W        = 4,
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int MAP_SIZE    = 12,
    parameter int EMPTY_GUARD = 3,
    parameter int CNT_W       = 16
) (
    input  logic             work_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             FIFO_Pool_Conv2_empty,
    input  logic [AER_W-1:0] Pool_AER_data_FIFO_o,
    input  logic             Pool_AER_data_FIFO_o_flag,
    input  logic             Pool_layer_done,
    output logic             Read_req,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CH_W-1:0]  evt_ch,
    output logic [ROW_W-1:0] evt_row,
    output logic [COL_W-1:0] evt_col,
    output logic             Conv2_step_done,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int GW = $clog2(EMPTY_GUARD + 1);
    localparam logic [GW-1:0] GUARD_MAX = GW'(EMPTY_GUARD);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_CLR, S_OUT, S_DONE} state_t;

    state_t           state;
    logic [AER_W-1:0] data_r;
    logic             done_pending;
    logic [GW-1:0]    guard_cnt;
    logic [CH_W-1:0]  ch_d;
    logic [ROW_W-1:0] row_d;
    logic [COL_W-1:0] col_d;
    logic             in_range;

    always_comb begin
        ch_d     = data_r[COL_W+ROW_W +: CH_W];
        row_d    = data_r[COL_W +: ROW_W];
        col_d    = data_r[0 +: COL_W];
        in_range = (int'(row_d) < MAP_SIZE) && (int'(col_d) < MAP_SIZE);
    end

    always_ff @(posedge work_clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            data_r          <= '0;
            done_pending    <= 1'b0;
            guard_cnt       <= '0;
            Read_req        <= 1'b0;
            evt_valid       <= 1'b0;
            evt_ch          <= '0;
            evt_row         <= '0;
            evt_col         <= '0;
            Conv2_step_done <= 1'b0;
            evt_cnt         <= '0;
            drop_cnt        <= '0;
        end else begin
            Conv2_step_done <= 1'b0;
            done_pending    <= done_pending | Pool_layer_done;
            // The FIFO write path is registered, so "empty" must persist a few idle cycles before it is trusted
            guard_cnt <= (state == S_IDLE && FIFO_Pool_Conv2_empty && done_pending)
                       ? ((guard_cnt == GUARD_MAX) ? guard_cnt : guard_cnt + 1'b1) : '0;
            case (state)
                S_IDLE: begin
                    if (enable && !FIFO_Pool_Conv2_empty) begin
                        Read_req <= 1'b1;
                        state    <= S_REQ;
                    end else if (done_pending && guard_cnt == GUARD_MAX) begin
                        Conv2_step_done <= 1'b1;
                        state           <= S_DONE;
                    end
                end
                S_REQ: begin
                    if (Pool_AER_data_FIFO_o_flag) begin
                        data_r   <= Pool_AER_data_FIFO_o;
                        Read_req <= 1'b0;
                        state    <= S_WAIT_CLR;
                    end
                end
                // The flag is a level; waiting for it to drop keeps one word from being captured twice
                S_WAIT_CLR: begin
                    if (!Pool_AER_data_FIFO_o_flag) begin
                        if (in_range) begin
                            evt_valid <= 1'b1;
                            evt_ch    <= ch_d;
                            evt_row   <= row_d;
                            evt_col   <= col_d;
                            state     <= S_OUT;
                        end else begin
                            drop_cnt <= (&drop_cnt) ? drop_cnt : drop_cnt + 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_OUT: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        evt_cnt   <= (&evt_cnt) ? evt_cnt : evt_cnt + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                // A layer-done pulse landing here belongs to the next timestep
                S_DONE: begin
                    done_pending <= Pool_layer_done;
                    evt_cnt      <= '0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2_aer_fetch.sv
// tb_conv2_aer_fetch: randomized self-checking bench with a queue-based FIFO and event model
module tb_conv2_aer_fetch;
    localparam int EMPTY_GUARD = 3;
    localparam int MAP_SIZE    = 12;
    localparam int CNT_MAX     = 65535;

    logic        work_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        FIFO_Pool_Conv2_empty;
    logic [11:0] Pool_AER_data_FIFO_o;
    logic        Pool_AER_data_FIFO_o_flag;
    logic        Pool_layer_done;
    logic        Read_req;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_ch;
    logic [3:0]  evt_row;
    logic [3:0]  evt_col;
    logic        Conv2_step_done;
    logic [15:0] evt_cnt;
    logic [15:0] drop_cnt;

    conv2_aer_fetch dut (
        .work_clk(work_clk),
        .rst_n(rst_n),
        .enable(enable),
        .FIFO_Pool_Conv2_empty(FIFO_Pool_Conv2_empty),
        .Pool_AER_data_FIFO_o(Pool_AER_data_FIFO_o),
        .Pool_AER_data_FIFO_o_flag(Pool_AER_data_FIFO_o_flag),
        .Pool_layer_done(Pool_layer_done),
        .Read_req(Read_req),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_ch(evt_ch),
        .evt_row(evt_row),
        .evt_col(evt_col),
        .Conv2_step_done(Conv2_step_done),
        .evt_cnt(evt_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 work_clk = ~work_clk;

    int          total = 0;
    int          bad = 0;
    logic [11:0] q[$];
    logic [11:0] exp_q[$];
    bit          srv, capd, stall, redo, acc, drop_nxt, val_nxt;
    bit          prev_valid, prev_ready, prev_done, lay_pend;
    int          hold_left, delay_left, hold_min, hold_max, rdy_pct;
    logic [11:0] cur, prev_f;
    int          model_evt, model_drop, quiet, done_cnt, n_reads, n_acc, cnt_at_done;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_map(input logic [11:0] w);
        int v;
        v = int'(w);
        return (v / 16 % 16 < MAP_SIZE) && (v % 16 < MAP_SIZE);
    endfunction

    task automatic push(input logic [11:0] w);
        q.push_back(w);
        FIFO_Pool_Conv2_empty = 1'b0;
    endtask

    task automatic cycle();
        logic        lay;
        logic [11:0] w;
        int          v;
        @(posedge work_clk);
        #1;
        lay = Pool_layer_done;
        Pool_layer_done = 1'b0;
        if (acc) model_evt = (model_evt == CNT_MAX) ? model_evt : model_evt + 1;
        if (drop_nxt) model_drop = (model_drop == CNT_MAX) ? model_drop : model_drop + 1;
        if (val_nxt) chk("evt_rise", evt_valid, 1);
        acc = 0;
        drop_nxt = 0;
        val_nxt = 0;
        chk("evt_cnt", evt_cnt, model_evt);
        chk("drop_cnt", drop_cnt, model_drop);
        if (prev_valid && !prev_ready) begin
            chk("hold_valid", evt_valid, 1);
            chk("hold_fields", {evt_ch, evt_row, evt_col}, prev_f);
        end
        if (Conv2_step_done) begin
            chk("done_pend", lay_pend, 1);
            chk("done_single", prev_done, 0);
            chk("done_guard", quiet >= EMPTY_GUARD, 1);
            done_cnt++;
            cnt_at_done = int'(evt_cnt);
            lay_pend = 0;
            model_evt = 0;
            quiet = 0;
            if (redo) begin
                Pool_layer_done = 1'b1;
                redo = 0;
            end
        end else begin
            quiet = (lay_pend && !Read_req && !evt_valid && !srv && q.size() == 0) ? quiet + 1 : 0;
        end
        if (lay) lay_pend = 1;
        // FIFO read responder
        if (srv) begin
            if (capd) chk("no_rereq", Read_req, 0);
            if (!Read_req) capd = 1;
            if (capd) begin
                if (hold_left > 0) hold_left--;
                else begin
                    Pool_AER_data_FIFO_o_flag = 1'b0;
                    Pool_AER_data_FIFO_o = 12'($urandom);
                    srv = 0;
                    capd = 0;
                    if (in_map(cur)) begin
                        exp_q.push_back(cur);
                        val_nxt = 1;
                    end else drop_nxt = 1;
                end
            end
        end else if (Read_req && !stall) begin
            if (q.size() == 0) chk("req_on_empty", Read_req, 0);
            else if (delay_left > 0) delay_left--;
            else begin
                cur = q.pop_front();
                n_reads++;
                srv = 1;
                capd = 0;
                Pool_AER_data_FIFO_o_flag = 1'b1;
                Pool_AER_data_FIFO_o = cur;
                hold_left = $urandom_range(hold_max, hold_min);
                delay_left = $urandom_range(2);
            end
        end
        // Conv2 consumer
        evt_ready = ($urandom_range(99) < rdy_pct);
        if (evt_valid && evt_ready) begin
            acc = 1;
            n_acc++;
            chk("evt_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                v = int'(w);
                chk("evt_ch", evt_ch, v / 256);
                chk("evt_row", evt_row, v / 16 % 16);
                chk("evt_col", evt_col, v % 16);
            end
        end
        prev_valid = evt_valid;
        prev_ready = evt_ready;
        prev_f = {evt_ch, evt_row, evt_col};
        prev_done = Conv2_step_done;
        FIFO_Pool_Conv2_empty = (q.size() == 0);
    endtask

    task automatic drain(input int limit);
        int n;
        bit busy;
        n = 0;
        busy = 1;
        while (busy && n < limit) begin
            cycle();
            n++;
            busy = q.size() != 0 || srv || exp_q.size() != 0 || evt_valid || Read_req || acc || drop_nxt || val_nxt;
        end
        chk("drain", busy, 0);
    endtask

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (done_cnt < target && n < limit) begin
            cycle();
            n++;
        end
        chk("done_cnt", done_cnt, target);
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!evt_valid && n < limit) begin
            cycle();
            n++;
        end
        chk("wait_valid", evt_valid, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge work_clk);
        #1;
        chk("rst_outs", {Read_req, evt_valid, evt_ch, evt_row, evt_col, Conv2_step_done, evt_cnt, drop_cnt}, 0);
        rst_n = 1'b1;
        q.delete();
        exp_q.delete();
        srv = 0; capd = 0; acc = 0; drop_nxt = 0; val_nxt = 0;
        prev_valid = 0; prev_ready = 0; prev_done = 0; lay_pend = 0;
        quiet = 0; model_evt = 0; model_drop = 0; delay_left = 0;
        Pool_AER_data_FIFO_o_flag = 1'b0;
        FIFO_Pool_Conv2_empty = 1'b1;
        Pool_layer_done = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, tgt, n;
        rst_n = 1'b0;
        enable = 1'b0;
        FIFO_Pool_Conv2_empty = 1'b1;
        Pool_AER_data_FIFO_o = '0;
        Pool_AER_data_FIFO_o_flag = 1'b0;
        Pool_layer_done = 1'b0;
        evt_ready = 1'b0;
        hold_min = 0;
        hold_max = 3;
        rdy_pct = 100;
        repeat (3) @(posedge work_clk);
        #1;
        chk("reset_state", {Read_req, evt_valid, evt_ch, evt_row, evt_col, Conv2_step_done, evt_cnt, drop_cnt}, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        // single word, request latency, one FIFO read
        push(12'h35A);
        cycle();
        chk("req_latency", Read_req, 1);
        drain(100);
        chk("t1_cnt", evt_cnt, 1);
        chk("t1_reads", n_reads, 1);
        // flag held high long after capture
        hold_min = 4;
        hold_max = 4;
        a0 = n_acc;
        push(12'h0AB);
        drain(100);
        chk("t2_one_evt", n_acc - a0, 1);
        chk("t2_reads", n_reads, 2);
        hold_min = 0;
        hold_max = 3;
        // backpressure
        rdy_pct = 0;
        push(12'h247);
        wait_valid(20);
        repeat (5) cycle();
        chk("t3_still_valid", evt_valid, 1);
        chk("t3_cnt_hold", evt_cnt, 2);
        rdy_pct = 100;
        drain(50);
        chk("t3_cnt", evt_cnt, 3);
        // out-of-range word followed by a good one
        push(12'h1C2);
        push(12'h123);
        drain(100);
        chk("t4_drop", drop_cnt, 1);
        chk("t4_cnt", evt_cnt, 4);
        Pool_layer_done = 1'b1;
        wait_done(1, 50);
        chk("t4_done_cnt", cnt_at_done, 4);
        cycle();
        chk("cnt_clear", evt_cnt, 0);
        // four words then step done
        push(12'h001);
        push(12'h2BB);
        push(12'h5A0);
        push(12'hF00);
        Pool_layer_done = 1'b1;
        wait_done(2, 300);
        chk("t5_cnt", cnt_at_done, 4);
        // a write inside the guard window postpones done
        cycle();
        Pool_layer_done = 1'b1;
        cycle();
        cycle();
        push(12'h456);
        wait_done(3, 300);
        chk("t5_late_cnt", cnt_at_done, 1);
        // layer done coinciding with the done pulse carries into the next step
        cycle();
        redo = 1;
        Pool_layer_done = 1'b1;
        wait_done(5, 100);
        chk("redo_cnt", cnt_at_done, 0);
        // randomized timesteps
        rdy_pct = 70;
        for (int s = 0; s < 6; s++) begin
            n = $urandom_range(15, 5);
            for (int k = 0; k < n; k++) begin
                enable = ($urandom_range(9) != 0);
                push(12'($urandom_range(4095)));
                repeat ($urandom_range(3)) cycle();
            end
            enable = 1'b1;
            repeat ($urandom_range(4)) cycle();
            tgt = done_cnt + 1;
            Pool_layer_done = 1'b1;
            wait_done(tgt, 2000);
            cycle();
            chk("rand_cnt_clear", evt_cnt, 0);
        end
        chk("rand_drained", q.size() + exp_q.size(), 0);
        // reset while requesting
        rdy_pct = 100;
        stall = 1;
        push(12'h377);
        n = 0;
        while (!Read_req && n < 10) begin
            cycle();
            n++;
        end
        chk("t7_in_req", Read_req, 1);
        do_reset();
        stall = 0;
        // reset while presenting an event
        rdy_pct = 0;
        push(12'h155);
        wait_valid(20);
        do_reset();
        rdy_pct = 100;
        push(12'h2B1);
        drain(100);
        chk("post_rst_cnt", evt_cnt, 1);
        chk("post_rst_drop", drop_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
